// File: rtl/fsm_op_sequencer.sv
// Feeds operand pairs from a small FIFO to the fsm arithmetic core, launches it by
// pulsing its reset, and returns each result on a valid/ready stream with a watchdog.
module fsm_op_sequencer #(
   parameter int unsigned WIDTH    = 32,
   parameter int unsigned OP_WIDTH = WIDTH + 3,
   parameter int unsigned DEPTH    = 4,
   parameter int unsigned TIMEOUT  = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [WIDTH-1:0]    in_a,
   input  logic [WIDTH-1:0]    in_b,
   output logic [WIDTH-1:0]    calc_a,
   output logic [WIDTH-1:0]    calc_b,
   output logic                calc_rst_n,
   input  logic [OP_WIDTH-1:0] calc_out,
   input  logic                calc_ready,
   output logic                res_valid,
   input  logic                res_ready,
   output logic [OP_WIDTH-1:0] res_data,
   output logic                busy,
   output logic                timeout_err
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned PW = AW + 1;
   localparam int unsigned CW = $clog2(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE,
      S_LAUNCH,
      S_WAIT,
      S_HOLD
   } state_t;

   state_t               state;
   logic [PW-1:0]        wr_ptr;
   logic [PW-1:0]        rd_ptr;
   logic [CW-1:0]        wait_cnt;
   logic [WIDTH-1:0]     mem_a [DEPTH];
   logic [WIDTH-1:0]     mem_b [DEPTH];

   logic                 fifo_full;
   logic                 fifo_empty;
   logic                 push;

   // Wrap bit distinguishes full from empty when the index bits match.
   assign fifo_empty = (wr_ptr == rd_ptr);
   assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign push       = in_valid && !fifo_full;
   assign in_ready   = !fifo_full;
   assign busy       = (state != S_IDLE) || !fifo_empty;

   // Operand storage needs no reset; occupancy is tracked by the pointers.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_a[wr_ptr[AW-1:0]] <= in_a;
         mem_b[wr_ptr[AW-1:0]] <= in_b;
      end
   end

   // calc_rst_n and res_valid are flops updated on the same edges as the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_IDLE;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         wait_cnt    <= '0;
         calc_a      <= '0;
         calc_b      <= '0;
         calc_rst_n  <= 1'b0;
         res_valid   <= 1'b0;
         res_data    <= '0;
         timeout_err <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         case (state)
            S_IDLE: begin
               if (!fifo_empty) begin
                  calc_a <= mem_a[rd_ptr[AW-1:0]];
                  calc_b <= mem_b[rd_ptr[AW-1:0]];
                  rd_ptr <= rd_ptr + PW'(1);
                  state  <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               wait_cnt   <= '0;
               calc_rst_n <= 1'b1;
               state      <= S_WAIT;
            end
            S_WAIT: begin
               wait_cnt <= wait_cnt + CW'(1);
               // Ready in the first WAIT cycle may be stale from before the reset pulse.
               if (calc_ready && (wait_cnt != '0)) begin
                  res_data  <= calc_out;
                  res_valid <= 1'b1;
                  state     <= S_HOLD;
               end else if (wait_cnt == CW'(TIMEOUT - 1)) begin
                  timeout_err <= 1'b1;
                  calc_rst_n  <= 1'b0;
                  state       <= S_IDLE;
               end
            end
            S_HOLD: begin
               if (res_ready) begin
                  res_valid  <= 1'b0;
                  calc_rst_n <= 1'b0;
                  state      <= S_IDLE;
               end
            end
            default: begin
               state      <= S_IDLE;
               calc_rst_n <= 1'b0;
               res_valid  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fsm_op_sequencer.sv
// Bench for fsm_op_sequencer: behavioural core model, result scoreboard,
// table-driven single ops plus fill, backpressure, watchdog, mid-op reset and wrap.
module tb_fsm_op_sequencer;

   localparam int unsigned WIDTH   = 32;
   localparam int unsigned OPW     = WIDTH + 3;
   localparam int unsigned DEPTH   = 4;
   localparam int unsigned TIMEOUT = 32;

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [WIDTH-1:0] calc_a;
   logic [WIDTH-1:0] calc_b;
   logic             calc_rst_n;
   logic [OPW-1:0]   calc_out;
   logic             calc_ready;
   logic             res_valid;
   logic             res_ready;
   logic [OPW-1:0]   res_data;
   logic             busy;
   logic             timeout_err;

   logic             stuck;
   logic [3:0]       ccnt;

   int               checks;
   int               errors;
   int               n_results;
   logic [OPW-1:0]   exp_q[$];

   typedef struct {
      logic [WIDTH-1:0] a;
      logic [WIDTH-1:0] b;
      logic [OPW-1:0]   res;
   } vec_t;

   vec_t vecs[8];

   fsm_op_sequencer #(
      .WIDTH   (WIDTH),
      .OP_WIDTH(OPW),
      .DEPTH   (DEPTH),
      .TIMEOUT (TIMEOUT)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_a       (in_a),
      .in_b       (in_b),
      .calc_a     (calc_a),
      .calc_b     (calc_b),
      .calc_rst_n (calc_rst_n),
      .calc_out   (calc_out),
      .calc_ready (calc_ready),
      .res_valid  (res_valid),
      .res_ready  (res_ready),
      .res_data   (res_data),
      .busy       (busy),
      .timeout_err(timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [OPW-1:0] core_f(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      return ((OPW'(a >> 1) + OPW'(b)) << 3) + ((OPW'(a) - OPW'(b >> 1)) << 2);
   endfunction

   // Core model: result and sticky ready appear 11 cycles after rst_n rises.
   always_ff @(posedge clk) begin
      if (!calc_rst_n) begin
         ccnt       <= 4'd0;
         calc_ready <= 1'b0;
         calc_out   <= '0;
      end else begin
         if (ccnt != 4'd11) ccnt <= ccnt + 4'd1;
         if (ccnt == 4'd10 && !stuck) begin
            calc_ready <= 1'b1;
            calc_out   <= core_f(calc_a, calc_b);
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // Scoreboard: every accepted result must match the oldest outstanding expectation.
   always @(negedge clk) begin
      #1;
      if (rst === 1'b0 && res_valid === 1'b1 && res_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_result actual=%0d required=none", res_data);
         end else begin
            chk("result", 64'(res_data), 64'(exp_q.pop_front()));
         end
         n_results++;
      end
   end

   task automatic push_one(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      int n;
      n = 0;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("push_accepted", 64'(in_ready), 64'd1);
      @(negedge clk);
      in_valid = 1'b0;
   endtask

   task automatic wait_res_valid(output int cycles);
      cycles = 0;
      while (!res_valid && cycles < 100) begin
         @(negedge clk);
         cycles++;
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while (busy && n < 300) begin
         @(negedge clk);
         n++;
      end
      chk("idle_reached", 64'(busy), 64'd0);
   endtask

   task automatic run_single(input vec_t v, input logic exp_to);
      int cycles;
      exp_q.push_back(v.res);
      push_one(v.a, v.b);
      wait_res_valid(cycles);
      chk("latency", 64'(cycles), 64'd14);
      chk("calc_a_latched", 64'(calc_a), 64'(v.a));
      chk("timeout_err_op", 64'(timeout_err), 64'(exp_to));
      wait_idle();
   endtask

   initial begin
      int  cycles;
      int  base;
      int  idx;
      int  cyc;
      logic pend;
      logic ok;

      checks    = 0;
      errors    = 0;
      n_results = 0;
      stuck     = 1'b0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      res_ready = 1'b1;

      vecs[0] = '{32'd10,  32'd4,  35'd104};
      vecs[1] = '{32'd1,   32'd0,  35'd4};
      vecs[2] = '{32'd2,   32'd0,  35'd16};
      vecs[3] = '{32'd3,   32'd0,  35'd20};
      vecs[4] = '{32'd4,   32'd0,  35'd32};
      vecs[5] = '{32'd6,   32'd2,  35'd60};
      vecs[6] = '{32'd0,   32'd0,  35'd0};
      vecs[7] = '{32'd100, 32'd50, 35'd1100};

      repeat (3) @(negedge clk);
      chk("rst_calc_rst_n", 64'(calc_rst_n), 64'd0);
      chk("rst_in_ready",   64'(in_ready),   64'd1);
      chk("rst_res_valid",  64'(res_valid),  64'd0);
      chk("rst_res_data",   64'(res_data),   64'd0);
      chk("rst_timeout",    64'(timeout_err), 64'd0);
      chk("rst_busy",       64'(busy),       64'd0);
      chk("rst_calc_a",     64'(calc_a),     64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Single operations from the table.
      for (int i = 0; i < 8; i++) run_single(vecs[i], 1'b0);

      // Fill: park the first op in HOLD so nothing pops, then fill the FIFO.
      base = n_results;
      res_ready = 1'b0;
      exp_q.push_back(vecs[0].res);
      push_one(vecs[0].a, vecs[0].b);
      wait_res_valid(cycles);
      chk("fill_hold", 64'(res_valid), 64'd1);
      for (int k = 1; k <= 4; k++) begin
         in_valid = 1'b1;
         in_a     = vecs[k].a;
         in_b     = vecs[k].b;
         exp_q.push_back(vecs[k].res);
         chk("in_ready_before_full", 64'(in_ready), 64'd1);
         @(negedge clk);
      end
      chk("in_ready_full", 64'(in_ready), 64'd0);
      in_a = 32'd99;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("in_ready_stays_full", 64'(in_ready), 64'd0);
      end
      in_valid  = 1'b0;
      res_ready = 1'b1;
      wait_idle();
      chk("fill_result_count", 64'(n_results - base), 64'd5);

      // Backpressure: result must hold and the next pair must not launch.
      base = n_results;
      res_ready = 1'b0;
      exp_q.push_back(vecs[5].res);
      push_one(vecs[5].a, vecs[5].b);
      exp_q.push_back(vecs[6].res);
      push_one(vecs[6].a, vecs[6].b);
      wait_res_valid(cycles);
      ok = 1'b1;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (!res_valid || res_data != vecs[5].res || calc_a != vecs[5].a || !calc_rst_n) ok = 1'b0;
      end
      chk("hold_stable", 64'(ok), 64'd1);
      chk("hold_busy", 64'(busy), 64'd1);
      res_ready = 1'b1;
      wait_idle();
      chk("bp_result_count", 64'(n_results - base), 64'd2);

      // Watchdog: stuck core aborts after TIMEOUT WAIT cycles.
      base  = n_results;
      stuck = 1'b1;
      push_one(32'd7, 32'd7);
      ok = 1'b1;
      for (int k = 0; k < 33; k++) begin
         @(negedge clk);
         if (res_valid) ok = 1'b0;
      end
      chk("wd_no_res_valid", 64'(ok), 64'd1);
      chk("wd_not_yet",      64'(timeout_err), 64'd0);
      @(negedge clk);
      chk("wd_set",          64'(timeout_err), 64'd1);
      chk("wd_core_reset",   64'(calc_rst_n),  64'd0);
      chk("wd_idle",         64'(busy),        64'd0);
      stuck = 1'b0;
      run_single(vecs[7], 1'b1);
      chk("wd_result_count", 64'(n_results - base), 64'd1);

      // Mid-operation reset during WAIT with a pair still queued.
      base = n_results;
      push_one(vecs[0].a, vecs[0].b);
      push_one(vecs[1].a, vecs[1].b);
      repeat (4) @(negedge clk);
      chk("pre_reset_wait", 64'(calc_rst_n), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mr_calc_rst_n", 64'(calc_rst_n),  64'd0);
      chk("mr_res_valid",  64'(res_valid),   64'd0);
      chk("mr_in_ready",   64'(in_ready),    64'd1);
      chk("mr_busy",       64'(busy),        64'd0);
      chk("mr_timeout",    64'(timeout_err), 64'd0);
      repeat (30) @(negedge clk);
      chk("mr_stays_idle", 64'(busy), 64'd0);
      chk("mr_no_result",  64'(n_results - base), 64'd0);

      // Wrap: stream 10 pairs with random backpressure.
      base = n_results;
      idx  = 0;
      pend = 1'b0;
      cyc  = 0;
      while ((n_results < base + 10) && cyc < 3000) begin
         if (pend) idx++;
         res_ready = 1'($urandom_range(0, 1));
         if (idx < 10) begin
            in_valid = 1'b1;
            in_a     = WIDTH'(idx);
            in_b     = WIDTH'(2 * idx);
         end else begin
            in_valid = 1'b0;
         end
         pend = in_valid && in_ready;
         if (pend) exp_q.push_back(OPW'(((idx / 2) + 2 * idx) * 8));
         @(negedge clk);
         cyc++;
      end
      in_valid  = 1'b0;
      res_ready = 1'b1;
      chk("wrap_result_count", 64'(n_results - base), 64'd10);
      wait_idle();
      chk("queue_drained", 64'(exp_q.size()), 64'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
